vending_fsm_multi: RTL and testbench
====================================

# vending_fsm_multi

Parametrised multi-product vending controller, the successor to the single-product coin/credit FSM. It accepts four coin denominations and tracks credit in configurable width. It serves NUM_PROD products with per-product prices, hands each vend to the dispenser over a valid/ready handshake, and returns change or refunds over a second handshake. It sits between the debounced coin/button front end and the dispenser/change-hopper drivers inside the TinyTapeout top.

## Interface
Parameters:
- CREDIT_W, 8: credit register width in price units.
- NUM_PROD, 4: number of products; must be 2..16.
- SEL_W, $clog2(NUM_PROD): product-index width.
- PRICES, {8'd15,8'd10,8'd7,8'd5}: packed NUM_PROD×CREDIT_W price table; product i uses slice i.
- MAX_CREDIT, 50: credit ceiling; must be < 2**CREDIT_W.
- TIMEOUT_CYC, 1000: inactivity limit; used only with VEND_TIMEOUT_EN.

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: asynchronous active-high reset.
- coin_valid, in, 1: one-cycle coin-inserted strobe.
- coin_code, in, 2: denomination code; 0→1, 1→2, 2→5, 3→10 units.
- coin_ack, out, 1: one-cycle pulse; coin accepted.
- coin_rej, out, 1: one-cycle pulse; coin rejected and returned physically.
- sel_valid, in, 1: one-cycle product-select strobe.
- sel_id, in, SEL_W: selected product.
- sel_nack, out, 1: one-cycle pulse; selection refused.
- cancel, in, 1: one-cycle refund request.
- disp_valid, out, 1: dispense request.
- disp_id, out, SEL_W: product to dispense.
- disp_ready, in, 1: dispenser accepts.
- change_valid, out, 1: change/refund request.
- change_amt, out, CREDIT_W: units to return.
- change_ready, in, 1: hopper accepts.
- credit, out, CREDIT_W: current credit, registered.
- busy, out, 1: high in VEND or CHANGE.

## Operation
- States: IDLE (credit==0), CREDIT (credit>0), VEND, CHANGE.
- Reset value of every output is 0. Reset clears the state to IDLE, credit to 0 and the latched sel_id. Reset mid-VEND or mid-CHANGE abandons the transaction without a refund.
- IDLE and CREDIT resolve same-cycle events with priority cancel > sel_valid > coin_valid. A coin that loses arbitration gets coin_rej.
- Coin handling: accept if credit+value ≤ MAX_CREDIT, which sets credit+=value and pulses coin_ack. Otherwise pulse coin_rej and leave credit unchanged. The sum is computed at CREDIT_W+1 bits, with no wrap.
- Selection: if sel_id ≥ NUM_PROD or credit < PRICES[sel_id], pulse sel_nack and stay. Otherwise latch sel_id and go to VEND.
- Cancel in CREDIT goes to CHANGE with change_amt=credit. Cancel in IDLE is ignored.
- VEND: disp_valid=1 and disp_id=latched id, held until disp_ready. On the handshake, credit-=price. Next state is CHANGE if the remainder is >0, else IDLE.
- CHANGE: change_valid=1 and change_amt=credit, held stable until change_ready. On the handshake, credit becomes 0 and the state goes to IDLE.
- In VEND or CHANGE: every coin_valid gets coin_rej, and sel_valid and cancel are ignored. No nack is issued for them.

## Timing
- All outputs are registered; pulses are exactly one cycle.
- Coin: strobe at edge N → coin_ack/coin_rej high and credit updated during cycle N+1.
- Select: strobe at edge N → disp_valid or sel_nack high in cycle N+1.
- Dispense: handshake at edge M → disp_valid low and credit decremented in M+1. change_valid is also high in M+1 if remainder>0.
- Change: handshake at edge K → change_valid low, credit=0, state IDLE in K+1.
- Back-to-back: a strobe in the cycle after an accepted coin is processed normally, at one event per cycle.
- disp_ready or change_ready asserted while the matching valid is low is ignored.

## Configuration
- Macro: VEND_TIMEOUT_EN.
- Defined: an inactivity counter runs in CREDIT and clears on any coin_valid, sel_valid or cancel. When it reaches TIMEOUT_CYC-1 with no event, the FSM enters CHANGE (auto-refund) on the next edge. The counter is held at 0 outside CREDIT.
- Undefined: no counter logic is built and credit is held indefinitely. TIMEOUT_CYC is unused.

## Structure
- Package vending_pkg holds:
  - the state enum (IDLE, CREDIT, VEND, CHANGE);
  - the coin-code→value constant table;
  - localparam defaults for CREDIT_W and MAX_CREDIT.
- Sub-module vending_timeout is the inactivity counter with clear and expire outputs. It is instantiated only under VEND_TIMEOUT_EN.

## Test plan
- Reset then coins 10,5 (codes 3,2) → two coin_ack pulses; credit 10 then 15.
- Credit 15, select product 2 (price 10) → disp_valid with disp_id=2. disp_ready asserted 3 cycles later → credit 5, change_valid with change_amt=5. change_ready → credit 0, IDLE.
- Credit 5, select product 3 (price 15) → sel_nack, credit still 5. Then select id 5 with NUM_PROD=4 → sel_nack.
- Credit 45, coin 10 → coin_rej, credit 45. Coin and sel_valid in the same cycle → vend proceeds and the coin gets coin_rej.
- Credit 7, cancel → change_amt=7. Coin during CHANGE → coin_rej. Assert rst mid-CHANGE → all outputs 0 in the same cycle.
- With VEND_TIMEOUT_EN and TIMEOUT_CYC=20: credit 2, idle 20 cycles → change_valid with change_amt=2. Without the macro: credit remains 2 after 100 idle cycles.

Source files
------------

// File: rtl/vending_pkg.sv
// vending_pkg: shared types and constants for the multi-product vending controller.
package vending_pkg;

    // Controller states: IDLE holds zero credit, CREDIT holds a positive balance.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StCredit = 2'd1,
        StVend   = 2'd2,
        StChange = 2'd3
    } state_e;

    // Defaults for the top-level credit width and ceiling.
    localparam int unsigned DefCreditW   = 8;
    localparam int unsigned DefMaxCredit = 50;

    // Coin code -> value in price units; code c uses slice c.
    localparam int unsigned CoinValW = 4;
    localparam logic [4*CoinValW-1:0] CoinValTable = {4'd10, 4'd5, 4'd2, 4'd1};

    function automatic logic [CoinValW-1:0] coin_value(input logic [1:0] code);
        return CoinValTable[code*CoinValW +: CoinValW];
    endfunction

endpackage

// File: rtl/vending_timeout.sv
// vending_timeout: inactivity counter that flags expiry after TIMEOUT_CYC quiet cycles.
// Held at zero while run_i is low; any event on clear_i restarts the count.
module vending_timeout #(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYC - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            at_last;

    assign at_last  = (cnt_q == LastCnt);
    assign expire_o = run_i && !clear_i && at_last;

    // Next count: clear outside the counting state or on activity, otherwise advance.
    always_comb begin
        cnt_d = cnt_q;
        if (!run_i || clear_i || at_last) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vending_fsm_multi.sv
// vending_fsm_multi: multi-product coin/credit vending controller with dispense and
// change handshakes. Define VEND_TIMEOUT_EN to build the inactivity auto-refund.
module vending_fsm_multi
    import vending_pkg::*;
#(
    parameter int unsigned                  CREDIT_W    = DefCreditW,
    parameter int unsigned                  NUM_PROD    = 4,
    parameter int unsigned                  SEL_W       = $clog2(NUM_PROD),
    parameter logic [NUM_PROD*CREDIT_W-1:0] PRICES      = {8'd15, 8'd10, 8'd7, 8'd5},
    parameter int unsigned                  MAX_CREDIT  = DefMaxCredit,
    parameter int unsigned                  TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_code,
    output logic                coin_ack,
    output logic                coin_rej,
    input  logic                sel_valid,
    input  logic [SEL_W-1:0]    sel_id,
    output logic                sel_nack,
    input  logic                cancel,
    output logic                disp_valid,
    output logic [SEL_W-1:0]    disp_id,
    input  logic                disp_ready,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    state_e              state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic                coin_ack_q, coin_ack_d;
    logic                coin_rej_q, coin_rej_d;
    logic                sel_nack_q, sel_nack_d;
    logic                disp_valid_q, change_valid_q, busy_q;
    logic [CREDIT_W-1:0] change_amt_q;

    logic [CREDIT_W:0]   coin_sum;
    logic [CREDIT_W-1:0] req_price, vend_price, remainder;
    logic                sel_in_range;
    logic                any_event;
    logic                timeout_expire;

    // Price lookup that never indexes outside the table.
    function automatic logic [CREDIT_W-1:0] price_of(input logic [SEL_W-1:0] idx);
        logic [CREDIT_W-1:0] p;
        p = '0;
        for (int unsigned i = 0; i < NUM_PROD; i++) begin
            if (32'(idx) == i) begin
                p = PRICES[i*CREDIT_W +: CREDIT_W];
            end
        end
        return p;
    endfunction

    // One bit wider than the credit so an over-ceiling sum cannot wrap.
    assign coin_sum     = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_value(coin_code));
    assign sel_in_range = (32'(sel_id) < NUM_PROD);
    assign req_price    = price_of(sel_id);
    assign vend_price   = price_of(sel_q);
    assign remainder    = credit_q - vend_price;
    assign any_event    = coin_valid | sel_valid | cancel;

`ifdef VEND_TIMEOUT_EN
    vending_timeout #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i    (clk),
        .rst_i    (rst),
        .run_i    (state_q == StCredit),
        .clear_i  (any_event),
        .expire_o (timeout_expire)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC ^ any_event;
    assign timeout_expire     = 1'b0;
`endif

    // Next-state, credit and pulse decisions.
    always_comb begin
        state_d    = state_q;
        credit_d   = credit_q;
        sel_d      = sel_q;
        coin_ack_d = 1'b0;
        coin_rej_d = 1'b0;
        sel_nack_d = 1'b0;
        unique case (state_q)
            StIdle, StCredit: begin
                // Cancel with nothing to refund is not an event, so it does not block others.
                if (cancel && (state_q == StCredit)) begin
                    state_d    = StChange;
                    coin_rej_d = coin_valid;
                end else if (sel_valid) begin
                    coin_rej_d = coin_valid;
                    if (!sel_in_range || (credit_q < req_price)) begin
                        sel_nack_d = 1'b1;
                    end else begin
                        sel_d   = sel_id;
                        state_d = StVend;
                    end
                end else if (coin_valid) begin
                    if (coin_sum <= (CREDIT_W + 1)'(MAX_CREDIT)) begin
                        credit_d   = coin_sum[CREDIT_W-1:0];
                        coin_ack_d = 1'b1;
                        state_d    = StCredit;
                    end else begin
                        coin_rej_d = 1'b1;
                    end
                end else if (timeout_expire) begin
                    state_d = StChange;
                end
            end
            StVend: begin
                coin_rej_d = coin_valid;
                if (disp_ready) begin
                    credit_d = remainder;
                    state_d  = (remainder != '0) ? StChange : StIdle;
                end
            end
            StChange: begin
                coin_rej_d = coin_valid;
                if (change_ready) begin
                    credit_d = '0;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, credit and registered outputs; reset abandons any open transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            credit_q       <= '0;
            sel_q          <= '0;
            coin_ack_q     <= 1'b0;
            coin_rej_q     <= 1'b0;
            sel_nack_q     <= 1'b0;
            disp_valid_q   <= 1'b0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            sel_q          <= sel_d;
            coin_ack_q     <= coin_ack_d;
            coin_rej_q     <= coin_rej_d;
            sel_nack_q     <= sel_nack_d;
            disp_valid_q   <= (state_d == StVend);
            change_valid_q <= (state_d == StChange);
            change_amt_q   <= (state_d == StChange) ? credit_d : '0;
            busy_q         <= (state_d == StVend) || (state_d == StChange);
        end
    end

    assign coin_ack     = coin_ack_q;
    assign coin_rej     = coin_rej_q;
    assign sel_nack     = sel_nack_q;
    assign disp_valid   = disp_valid_q;
    assign disp_id      = sel_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign credit       = credit_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vending_fsm_multi.sv
// tb_vending_fsm_multi: directed scenarios plus randomized traffic against a
// behavioural model of the vending controller.
module tb_vending_fsm_multi;

    localparam int unsigned TimeoutCyc = 20;

    logic       clk = 1'b0;
    logic       rst;
    logic       coin_valid;
    logic [1:0] coin_code;
    logic       coin_ack, coin_rej;
    logic       sel_valid;
    logic [2:0] sel_id;
    logic       sel_nack;
    logic       cancel;
    logic       disp_valid;
    logic [2:0] disp_id;
    logic       disp_ready;
    logic       change_valid;
    logic [7:0] change_amt;
    logic       change_ready;
    logic [7:0] credit;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int prices[4]    = '{5, 7, 10, 15};
    int coin_vals[4] = '{1, 2, 5, 10};

    vending_fsm_multi #(
        .SEL_W       (3),
        .TIMEOUT_CYC (TimeoutCyc)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .coin_valid   (coin_valid),
        .coin_code    (coin_code),
        .coin_ack     (coin_ack),
        .coin_rej     (coin_rej),
        .sel_valid    (sel_valid),
        .sel_id       (sel_id),
        .sel_nack     (sel_nack),
        .cancel       (cancel),
        .disp_valid   (disp_valid),
        .disp_id      (disp_id),
        .disp_ready   (disp_ready),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .change_ready (change_ready),
        .credit       (credit),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        coin_valid   = 1'b0;
        coin_code    = 2'd0;
        sel_valid    = 1'b0;
        sel_id       = 3'd0;
        cancel       = 1'b0;
        disp_ready   = 1'b0;
        change_ready = 1'b0;
    endtask

    task automatic drive_coin(input logic [1:0] c);
        clear_inputs();
        coin_valid = 1'b1;
        coin_code  = c;
        tick();
        clear_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        #12;
        checks++;
        if ({coin_ack, coin_rej, sel_nack, disp_valid, change_valid, busy, disp_id, change_amt,
             credit} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", {coin_ack, coin_rej, sel_nack,
                     disp_valid, change_valid, busy, disp_id, change_amt, credit});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_coins();
        drive_coin(2'd3);
        checks++;
        if ({coin_ack, coin_rej, credit} !== {1'b1, 1'b0, 8'd10}) begin
            errors++;
            $display("FAIL coin10: got ack=%b rej=%b credit=%0d want 1 0 10", coin_ack, coin_rej,
                     credit);
        end
        tick();
        checks++;
        if (coin_ack !== 1'b0) begin
            errors++;
            $display("FAIL ack_pulse_width: got %b want 0", coin_ack);
        end
        drive_coin(2'd2);
        checks++;
        if ({coin_ack, coin_rej, credit} !== {1'b1, 1'b0, 8'd15}) begin
            errors++;
            $display("FAIL coin5: got ack=%b rej=%b credit=%0d want 1 0 15", coin_ack, coin_rej,
                     credit);
        end
    endtask

    task automatic test_vend_change();
        sel_valid = 1'b1;
        sel_id    = 3'd2;
        tick();
        clear_inputs();
        checks++;
        if ({disp_valid, disp_id, busy, sel_nack} !== {1'b1, 3'd2, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL vend_start: got dv=%b id=%0d busy=%b nack=%b want 1 2 1 0", disp_valid,
                     disp_id, busy, sel_nack);
        end
        repeat (3) tick();
        checks++;
        if ({disp_valid, credit} !== {1'b1, 8'd15}) begin
            errors++;
            $display("FAIL vend_hold: got dv=%b credit=%0d want 1 15", disp_valid, credit);
        end
        disp_ready = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if ({disp_valid, change_valid, change_amt, credit} !== {1'b0, 1'b1, 8'd5, 8'd5}) begin
            errors++;
            $display("FAIL vend_done: got dv=%b cv=%b amt=%0d credit=%0d want 0 1 5 5",
                     disp_valid, change_valid, change_amt, credit);
        end
        change_ready = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if ({change_valid, credit, busy} !== {1'b0, 8'd0, 1'b0}) begin
            errors++;
            $display("FAIL change_done: got cv=%b credit=%0d busy=%b want 0 0 0", change_valid,
                     credit, busy);
        end
    endtask

    task automatic test_nack();
        drive_coin(2'd2);
        sel_valid = 1'b1;
        sel_id    = 3'd3;
        tick();
        clear_inputs();
        checks++;
        if ({sel_nack, disp_valid, credit} !== {1'b1, 1'b0, 8'd5}) begin
            errors++;
            $display("FAIL nack_price: got nack=%b dv=%b credit=%0d want 1 0 5", sel_nack,
                     disp_valid, credit);
        end
        tick();
        checks++;
        if (sel_nack !== 1'b0) begin
            errors++;
            $display("FAIL nack_pulse_width: got %b want 0", sel_nack);
        end
        sel_valid = 1'b1;
        sel_id    = 3'd5;
        tick();
        clear_inputs();
        checks++;
        if ({sel_nack, disp_valid, credit} !== {1'b1, 1'b0, 8'd5}) begin
            errors++;
            $display("FAIL nack_range: got nack=%b dv=%b credit=%0d want 1 0 5", sel_nack,
                     disp_valid, credit);
        end
        cancel = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if ({change_valid, change_amt} !== {1'b1, 8'd5}) begin
            errors++;
            $display("FAIL cancel5: got cv=%b amt=%0d want 1 5", change_valid, change_amt);
        end
        change_ready = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_coin_reject();
        drive_coin(2'd3);
        drive_coin(2'd3);
        drive_coin(2'd3);
        drive_coin(2'd3);
        drive_coin(2'd2);
        drive_coin(2'd3);
        checks++;
        if ({coin_ack, coin_rej, credit} !== {1'b0, 1'b1, 8'd45}) begin
            errors++;
            $display("FAIL coin_over_max: got ack=%b rej=%b credit=%0d want 0 1 45", coin_ack,
                     coin_rej, credit);
        end
        coin_valid = 1'b1;
        coin_code  = 2'd0;
        sel_valid  = 1'b1;
        sel_id     = 3'd3;
        tick();
        clear_inputs();
        checks++;
        if ({disp_valid, disp_id, coin_ack, coin_rej, credit} !==
            {1'b1, 3'd3, 1'b0, 1'b1, 8'd45}) begin
            errors++;
            $display("FAIL coin_sel_same_cycle: got dv=%b id=%0d ack=%b rej=%b credit=%0d want 1 3 0 1 45",
                     disp_valid, disp_id, coin_ack, coin_rej, credit);
        end
        disp_ready = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if ({change_valid, change_amt, credit} !== {1'b1, 8'd30, 8'd30}) begin
            errors++;
            $display("FAIL vend15_change: got cv=%b amt=%0d credit=%0d want 1 30 30",
                     change_valid, change_amt, credit);
        end
        change_ready = 1'b1;
        tick();
        clear_inputs();
    endtask

    task automatic test_cancel_reset();
        drive_coin(2'd2);
        drive_coin(2'd1);
        cancel = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if ({change_valid, change_amt, busy} !== {1'b1, 8'd7, 1'b1}) begin
            errors++;
            $display("FAIL cancel7: got cv=%b amt=%0d busy=%b want 1 7 1", change_valid,
                     change_amt, busy);
        end
        drive_coin(2'd3);
        checks++;
        if ({coin_rej, coin_ack, change_valid, change_amt, credit} !==
            {1'b1, 1'b0, 1'b1, 8'd7, 8'd7}) begin
            errors++;
            $display("FAIL coin_in_change: got rej=%b ack=%b cv=%b amt=%0d credit=%0d want 1 0 1 7 7",
                     coin_rej, coin_ack, change_valid, change_amt, credit);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({coin_ack, coin_rej, sel_nack, disp_valid, change_valid, busy, disp_id, change_amt,
             credit} !== 25'd0) begin
            errors++;
            $display("FAIL async_reset_mid_change: got %h want 0", {coin_ack, coin_rej, sel_nack,
                     disp_valid, change_valid, busy, disp_id, change_amt, credit});
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        checks++;
        if ({change_valid, busy, credit} !== {1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL after_reset_idle: got cv=%b busy=%b credit=%0d want 0 0 0",
                     change_valid, busy, credit);
        end
    endtask

    task automatic test_timeout();
        drive_coin(2'd1);
`ifdef VEND_TIMEOUT_EN
        repeat (TimeoutCyc - 1) tick();
        checks++;
        if ({change_valid, credit} !== {1'b0, 8'd2}) begin
            errors++;
            $display("FAIL timeout_early: got cv=%b credit=%0d want 0 2", change_valid, credit);
        end
        tick();
        checks++;
        if ({change_valid, change_amt} !== {1'b1, 8'd2}) begin
            errors++;
            $display("FAIL timeout_refund: got cv=%b amt=%0d want 1 2", change_valid, change_amt);
        end
`else
        repeat (100) tick();
        checks++;
        if ({change_valid, credit} !== {1'b0, 8'd2}) begin
            errors++;
            $display("FAIL credit_held: got cv=%b credit=%0d want 0 2", change_valid, credit);
        end
        cancel = 1'b1;
        tick();
        clear_inputs();
`endif
        change_ready = 1'b1;
        tick();
        clear_inputs();
        checks++;
        if ({change_valid, credit} !== {1'b0, 8'd0}) begin
            errors++;
            $display("FAIL timeout_cleanup: got cv=%b credit=%0d want 0 0", change_valid, credit);
        end
    endtask

    task automatic test_back_to_back();
        int exp_credit = 0;
        clear_inputs();
        disp_ready   = 1'b1;
        change_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            coin_valid = 1'b1;
            coin_code  = 2'(i);
            tick();
            exp_credit += coin_vals[i];
            checks++;
            if ({coin_ack, disp_valid, change_valid, credit} !==
                {1'b1, 1'b0, 1'b0, 8'(exp_credit)}) begin
                errors++;
                $display("FAIL b2b_coin%0d: got ack=%b dv=%b cv=%b credit=%0d want 1 0 0 %0d", i,
                         coin_ack, disp_valid, change_valid, credit, exp_credit);
            end
        end
        coin_valid = 1'b0;
        sel_valid  = 1'b1;
        sel_id     = 3'd1;
        tick();
        sel_valid = 1'b0;
        checks++;
        if ({disp_valid, disp_id, credit} !== {1'b1, 3'd1, 8'd18}) begin
            errors++;
            $display("FAIL b2b_sel: got dv=%b id=%0d credit=%0d want 1 1 18", disp_valid, disp_id,
                     credit);
        end
        tick();
        checks++;
        if ({disp_valid, change_valid, change_amt, credit} !== {1'b0, 1'b1, 8'd11, 8'd11}) begin
            errors++;
            $display("FAIL b2b_vend: got dv=%b cv=%b amt=%0d credit=%0d want 0 1 11 11",
                     disp_valid, change_valid, change_amt, credit);
        end
        tick();
        checks++;
        if ({change_valid, busy, credit} !== {1'b0, 1'b0, 8'd0}) begin
            errors++;
            $display("FAIL b2b_change: got cv=%b busy=%b credit=%0d want 0 0 0", change_valid,
                     busy, credit);
        end
        clear_inputs();
    endtask

    // Model: mode 0 collecting coins, 1 waiting for the dispenser, 2 paying out.
    task automatic test_random();
        int  m_credit = 0;
        int  m_mode   = 0;
        int  m_id     = 0;
        int  m_idle   = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            bit          quiet;
            int unsigned pc, ps, pk;
            bit          e_ack, e_rej, e_nack, had_credit, ev;
            logic [24:0] exp_v, got_v;
            quiet = ((cyc / 200) % 2) == 1;
            pc    = quiet ? 3 : 30;
            ps    = quiet ? 2 : 12;
            pk    = quiet ? 1 : 4;
            coin_valid   = ($urandom_range(99) < pc);
            coin_code    = 2'($urandom_range(3));
            sel_valid    = ($urandom_range(99) < ps);
            sel_id       = 3'($urandom_range(7));
            cancel       = ($urandom_range(99) < pk);
            disp_ready   = ($urandom_range(99) < 40);
            change_ready = ($urandom_range(99) < 40);

            e_ack      = 1'b0;
            e_rej      = 1'b0;
            e_nack     = 1'b0;
            had_credit = (m_credit > 0);
            ev         = coin_valid || sel_valid || cancel;
            if (m_mode == 0) begin
                if (cancel && m_credit > 0) begin
                    m_mode = 2;
                    e_rej  = coin_valid;
                end else if (sel_valid) begin
                    e_rej = coin_valid;
                    if (sel_id >= 4 || m_credit < prices[sel_id]) begin
                        e_nack = 1'b1;
                    end else begin
                        m_id   = sel_id;
                        m_mode = 1;
                    end
                end else if (coin_valid) begin
                    if (m_credit + coin_vals[coin_code] <= 50) begin
                        m_credit += coin_vals[coin_code];
                        e_ack = 1'b1;
                    end else begin
                        e_rej = 1'b1;
                    end
                end
`ifdef VEND_TIMEOUT_EN
                else if (had_credit && m_idle == TimeoutCyc - 1) begin
                    m_mode = 2;
                end
                if (had_credit && !ev && m_mode == 0) m_idle++;
                else m_idle = 0;
`endif
            end else if (m_mode == 1) begin
                e_rej = coin_valid;
                if (disp_ready) begin
                    m_credit -= prices[m_id];
                    m_mode = (m_credit > 0) ? 2 : 0;
                end
            end else begin
                e_rej = coin_valid;
                if (change_ready) begin
                    m_credit = 0;
                    m_mode   = 0;
                end
            end

            tick();
            exp_v = {e_ack, e_rej, e_nack, m_mode == 1, m_mode == 2, m_mode != 0, 8'(m_credit),
                     (m_mode == 2) ? 8'(m_credit) : 8'd0, (m_mode == 1) ? 3'(m_id) : 3'd0};
            got_v = {coin_ack, coin_rej, sel_nack, disp_valid, change_valid, busy, credit,
                     change_amt, disp_valid ? disp_id : 3'd0};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL random_cycle%0d: got %h want %h (ack rej nack dv cv busy credit amt id)",
                         cyc, got_v, exp_v);
            end
        end
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_coins();
        test_vend_change();
        test_nack();
        test_coin_reject();
        test_cancel_reset();
        test_timeout();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
